// File: rtl/rtc_bridge_pkg.sv
// Shared types and constants for the RTC port bridge: commit FSM states,
// control/status bit positions and default port addresses.
package rtc_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } commit_state_e;

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_DISCARD_BIT = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DIRTY_BIT = 1;
    localparam int STAT_SEEN_BIT  = 2;

    localparam logic [7:0] DEF_BASE_ID = 8'h00;
    localparam logic [7:0] DEF_CTRL_ID = 8'hF0;
    localparam logic [7:0] DEF_STAT_ID = 8'hF1;
    localparam logic [7:0] DEF_KEY_ID  = 8'hF2;

endpackage

// File: rtl/rtc_port_bridge_if.sv
// PicoBlaze port-mapped I/O bus: the CPU is the master, peripherals are slaves.
interface rtc_port_bridge_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        port_id;
    logic [DATA_W-1:0] out_port;
    logic              write_strobe;
    logic              read_strobe;
    logic [DATA_W-1:0] in_port;

    modport master (output port_id, out_port, write_strobe, read_strobe, input in_port);
    modport slave  (input port_id, out_port, write_strobe, read_strobe, output in_port);
endinterface

// File: rtl/key_event_latch.sv
// Keypad event flags, cleared by a read of the key register; a new pulse beats the clear.
// PORT_BRIDGE_IRQ_EN adds a level interrupt held until acknowledged.
module key_event_latch
    import rtc_bridge_pkg::*;
#(
    parameter int NUM_KEYS = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_pulse,
    input  logic                key_read,
`ifdef PORT_BRIDGE_IRQ_EN
    input  logic                interrupt_ack,
    output logic                interrupt,
`endif
    output logic [NUM_KEYS-1:0] pending
);

    logic [NUM_KEYS-1:0] pending_r;

    // Pending flags: set by pulses, cleared by reads of the key port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= '0;
        end else if (key_read) begin
            pending_r <= key_pulse;
        end else begin
            pending_r <= pending_r | key_pulse;
        end
    end

    assign pending = pending_r;

`ifdef PORT_BRIDGE_IRQ_EN
    logic irq_r;

    // Interrupt: ack drops it for one cycle, it returns while flags remain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else if (interrupt_ack) begin
            irq_r <= 1'b0;
        end else if (|pending_r) begin
            irq_r <= 1'b1;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign interrupt = irq_r;
`endif

endmodule

// File: rtl/rtc_port_bridge.sv
// RTC port bridge: shadow field registers with dirty tracking, RTC snapshot load,
// sequenced commit pass and CPU read mux. PORT_BRIDGE_IRQ_EN adds a key interrupt.
module rtc_port_bridge
    import rtc_bridge_pkg::*;
#(
    parameter int         NUM_FIELDS = 9,
    parameter int         DATA_W     = 8,
    parameter int         NUM_KEYS   = 7,
    parameter logic [7:0] BASE_ID    = DEF_BASE_ID,
    parameter logic [7:0] CTRL_ID    = DEF_CTRL_ID,
    parameter logic [7:0] STAT_ID    = DEF_STAT_ID,
    parameter logic [7:0] KEY_ID     = DEF_KEY_ID
) (
    input  logic                         clk,
    input  logic                         reset,
    rtc_port_bridge_if.slave             bus,
    input  logic [NUM_KEYS-1:0]          key_pulse,
    input  logic [NUM_FIELDS*DATA_W-1:0] rtc_rd_data,
    input  logic                         rtc_rd_valid,
    output logic [NUM_FIELDS*DATA_W-1:0] field_q,
    output logic [NUM_FIELDS-1:0]        habilita,
    output logic                         commit_busy,
    output logic                         commit_done
`ifdef PORT_BRIDGE_IRQ_EN
    ,
    output logic                         interrupt,
    input  logic                         interrupt_ack
`endif
);

    localparam int IDX_W = $clog2(NUM_FIELDS + 1);

    commit_state_e                state_r;
    logic [IDX_W-1:0]             idx_r;
    logic [NUM_FIELDS-1:0]        dirty_r;
    logic [NUM_FIELDS-1:0]        habilita_r;
    logic [NUM_FIELDS*DATA_W-1:0] shadow_r;
    logic                         seen_r;
    logic                         busy_r;
    logic                         done_r;

    logic [NUM_FIELDS-1:0] field_wr_s;
    logic [NUM_FIELDS-1:0] visit_s;
    logic [NUM_FIELDS-1:0] dirty_base_s;
    logic [NUM_FIELDS-1:0] pulse_s;
    logic [NUM_KEYS-1:0]   pending_s;
    logic [DATA_W-1:0]     rd_data_s;
    logic                  idle_s, ctrl_wr_s, commit_s, discard_s, snap_s, stat_rd_s, key_rd_s;

    assign idle_s    = (state_r == IDLE);
    assign ctrl_wr_s = bus.write_strobe & (bus.port_id == CTRL_ID) & idle_s;
    assign commit_s  = ctrl_wr_s & bus.out_port[CTRL_COMMIT_BIT];
    assign discard_s = ctrl_wr_s & bus.out_port[CTRL_DISCARD_BIT];
    assign snap_s    = rtc_rd_valid & idle_s;
    assign stat_rd_s = bus.read_strobe & (bus.port_id == STAT_ID);
    assign key_rd_s  = bus.read_strobe & (bus.port_id == KEY_ID);

    // Field write decode; field 0 is visited on the commit edge itself, field k at idx k
    always_comb begin
        field_wr_s = '0;
        visit_s    = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            field_wr_s[i] = bus.write_strobe & (bus.port_id == BASE_ID + 8'(i));
            visit_s[i]    = (state_r == SCAN) & (idx_r == IDX_W'(i));
        end
    end

    // Dirty set after an optional discard, and the field pulsed at this edge
    always_comb begin
        dirty_base_s = dirty_r;
        pulse_s      = '0;
        if (discard_s) begin
            dirty_base_s = '0;
        end else begin
            dirty_base_s = dirty_r;
        end
        if (commit_s) begin
            pulse_s[0] = dirty_base_s[0];
        end else begin
            pulse_s = visit_s & dirty_r;
        end
    end

    // Commit sequencer with registered enables; a same-edge write keeps the field dirty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            dirty_r    <= '0;
            habilita_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            habilita_r <= pulse_s;
            dirty_r    <= (dirty_base_s & ~pulse_s) | field_wr_s;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (commit_s) begin
                        state_r <= SCAN;
                        idx_r   <= IDX_W'(1);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    busy_r <= 1'b1;
                    if (idx_r == IDX_W'(NUM_FIELDS)) begin
                        state_r <= DONE;
                        idx_r   <= '0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SCAN;
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers: CPU write beats the snapshot, dirty fields ignore the snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= '0;
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (field_wr_s[i]) begin
                    shadow_r[i*DATA_W +: DATA_W] <= bus.out_port;
                end else if (snap_s && !dirty_r[i]) begin
                    shadow_r[i*DATA_W +: DATA_W] <= rtc_rd_data[i*DATA_W +: DATA_W];
                end else begin
                    shadow_r[i*DATA_W +: DATA_W] <= shadow_r[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Snapshot-seen flag: set by an accepted snapshot, cleared by a status read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_r <= 1'b0;
        end else if (snap_s) begin
            seen_r <= 1'b1;
        end else if (stat_rd_s) begin
            seen_r <= 1'b0;
        end else begin
            seen_r <= seen_r;
        end
    end

    key_event_latch #(
        .NUM_KEYS (NUM_KEYS)
    ) u_keys (
        .clk           (clk),
        .reset         (reset),
        .key_pulse     (key_pulse),
        .key_read      (key_rd_s),
`ifdef PORT_BRIDGE_IRQ_EN
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
`endif
        .pending       (pending_s)
    );

    // CPU read mux; unmapped and write-only ports read as zero
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (bus.port_id == BASE_ID + 8'(i)) begin
                rd_data_s = shadow_r[i*DATA_W +: DATA_W];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        if (bus.port_id == STAT_ID) begin
            rd_data_s                 = '0;
            rd_data_s[STAT_SEEN_BIT]  = seen_r;
            rd_data_s[STAT_DIRTY_BIT] = |dirty_r;
            rd_data_s[STAT_BUSY_BIT]  = busy_r;
        end else if (bus.port_id == KEY_ID) begin
            rd_data_s = DATA_W'(pending_s);
        end else begin
            rd_data_s = rd_data_s;
        end
    end

    assign bus.in_port  = rd_data_s;
    assign field_q      = shadow_r;
    assign habilita     = habilita_r;
    assign commit_busy  = busy_r;
    assign commit_done  = done_r;

endmodule

// File: tb/tb_rtc_port_bridge.sv
// Bench for rtc_port_bridge: directed bus sequences, a cycle model checked every
// falling edge, and literal expectations for the key scenarios.
module tb_rtc_port_bridge;

    localparam int NF = 9;
    localparam logic [7:0] CTRL = 8'hF0;
    localparam logic [7:0] STAT = 8'hF1;
    localparam logic [7:0] KEYP = 8'hF2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    key_pulse = 7'h00;
    logic [NF*8-1:0] rtc_rd_data = '0;
    logic          rtc_rd_valid = 1'b0;
    logic [NF*8-1:0] field_q;
    logic [NF-1:0] habilita;
    logic          commit_busy, commit_done;
`ifdef PORT_BRIDGE_IRQ_EN
    logic          interrupt;
    logic          interrupt_ack = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    rtc_port_bridge_if #(.DATA_W(8)) bus ();

    rtc_port_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .key_pulse    (key_pulse),
        .rtc_rd_data  (rtc_rd_data),
        .rtc_rd_valid (rtc_rd_valid),
        .field_q      (field_q),
        .habilita     (habilita),
        .commit_busy  (commit_busy),
        .commit_done  (commit_done)
`ifdef PORT_BRIDGE_IRQ_EN
        ,
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_shadow [NF];
    bit [NF-1:0] m_dirty = '0;
    bit [NF-1:0] m_hab = '0;
    bit [6:0]    m_pend = '0;
    bit          m_seen = 1'b0;
    int          m_pass = -1;   // cycles since the commit edge, -1 when no pass runs

    always @(posedge clk or negedge reset) begin : model
        bit          idle;
        bit [NF-1:0] wr;
        bit [NF-1:0] d0;
        bit [NF-1:0] hab_n;
        int          f;
        if (!reset) begin
            for (int i = 0; i < NF; i++) m_shadow[i] = 8'h00;
            m_dirty = '0; m_hab = '0; m_pend = '0; m_seen = 1'b0; m_pass = -1;
        end else begin
            idle  = (m_pass < 0);
            hab_n = '0;
            d0    = m_dirty;
            for (int i = 0; i < NF; i++) wr[i] = bus.write_strobe && (bus.port_id == 8'(i));
            if (idle && rtc_rd_valid)
                for (int i = 0; i < NF; i++)
                    if (!d0[i] && !wr[i]) m_shadow[i] = rtc_rd_data[i*8 +: 8];
            if (idle) begin
                if (bus.write_strobe && bus.port_id == CTRL) begin
                    if (bus.out_port[1]) m_dirty = '0;
                    if (bus.out_port[0]) begin
                        hab_n[0] = m_dirty[0]; m_dirty[0] = 1'b0; m_pass = 1;
                    end
                end
            end else if (m_pass < NF) begin
                f = m_pass;
                hab_n[f] = m_dirty[f]; m_dirty[f] = 1'b0; m_pass = m_pass + 1;
            end else if (m_pass == NF) begin
                m_pass = NF + 1;
            end else begin
                m_pass = -1;
            end
            for (int i = 0; i < NF; i++)
                if (wr[i]) begin m_shadow[i] = bus.out_port; m_dirty[i] = 1'b1; end
            if (idle && rtc_rd_valid) m_seen = 1'b1;
            else if (bus.read_strobe && bus.port_id == STAT) m_seen = 1'b0;
            m_pend = ((bus.read_strobe && bus.port_id == KEYP) ? 7'h00 : m_pend) | key_pulse;
            m_hab = hab_n;
        end
    end

    function automatic logic [NF*8-1:0] model_fields();
        logic [NF*8-1:0] r;
        for (int i = 0; i < NF; i++) r[i*8 +: 8] = m_shadow[i];
        return r;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] id);
        if (id < 8'(NF)) return m_shadow[id];
        if (id == STAT) return {5'b00000, m_seen, |m_dirty, (m_pass > 0)};
        if (id == KEYP) return {1'b0, m_pend};
        return 8'h00;
    endfunction

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        check("field_q", field_q, model_fields());
        check("habilita", habilita, m_hab);
        check("commit_busy", commit_busy, (m_pass > 0));
        check("commit_done", commit_done, (m_pass == NF + 1));
        check("in_port", bus.in_port, model_read(bus.port_id));
    end

    // ---------------- stimulus helpers ----------------
    int          cyc = 0;
    logic [NF-1:0] hab_log [64];
    logic          done_log [64];
    logic [7:0]    rd_last;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (cyc < 64) begin hab_log[cyc] = habilita; done_log[cyc] = commit_done; end
            rd_last = bus.in_port;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] id, input logic [7:0] d);
        bus.port_id = id; bus.out_port = d; bus.write_strobe = 1'b1;
        tick(1);
        bus.write_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] id, output logic [7:0] d);
        bus.port_id = id; bus.read_strobe = 1'b1;
        tick(1);
        bus.read_strobe = 1'b0;
        d = rd_last;
    endtask

    task automatic start_pass(input logic [7:0] ctrl);
        bus_write(CTRL, ctrl);
        cyc = 1;
        for (int k = 0; k < 64; k++) begin hab_log[k] = '0; done_log[k] = 1'b0; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (commit_busy && n < 30) begin tick(1); n++; end
        check("idle_timeout", commit_busy, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [7:0]    rd;
        logic [NF-1:0] acc;
        logic          dn;
        bus.port_id = 8'h00; bus.out_port = 8'h00;
        bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_field_q", field_q, '0);
        check("rst_habilita", habilita, '0);
        check("rst_busy", commit_busy, 1'b0);
        check("rst_done", commit_done, 1'b0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        bus_read(STAT, rd); check("rst_stat", rd, 8'h00);

        // Snapshot with field 3 dirty
        bus_write(8'h03, 8'h07);
        rtc_rd_data = {NF{8'h11}}; rtc_rd_valid = 1'b1; tick(1); rtc_rd_valid = 1'b0;
        check("snap_f3", field_q[3*8 +: 8], 8'h07);
        check("snap_f0", field_q[0 +: 8], 8'h11);
        check("snap_f8", field_q[8*8 +: 8], 8'h11);
        bus_read(STAT, rd); check("stat_seen", rd, 8'h06);
        bus_read(STAT, rd); check("stat_cleared", rd, 8'h02);
        bus_write(CTRL, 8'h02);
        bus_read(STAT, rd); check("discard_stat", rd, 8'h00);

        // Basic commit latency
        bus_write(8'h02, 8'h24);
        bus_write(8'h05, 8'h59);
        start_pass(8'h01);
        tick(10);
        check("t1_hab2", hab_log[2], 9'h000);
        check("t1_hab3", hab_log[3], 9'h004);
        check("t1_hab6", hab_log[6], 9'h020);
        check("t1_done9", done_log[9], 1'b0);
        check("t1_done10", done_log[10], 1'b1);
        wait_idle();

        // Write to a not-yet-visited field during the pass
        start_pass(8'h01);
        tick(3);
        bus_write(8'h07, 8'h3C);
        tick(6);
        check("pa_hab8", hab_log[8], 9'h080);
        check("pa_done10", done_log[10], 1'b1);
        wait_idle();

        // Passed field, same-cycle visit, ignored CTRL and snapshot during the pass
        bus_write(8'h05, 8'hA5);
        start_pass(8'h01);
        tick(3);
        bus_write(8'h01, 8'h5A);
        bus_write(8'h05, 8'hC3);
        bus_write(CTRL, 8'h02);
        rtc_rd_data = {NF{8'hEE}}; rtc_rd_valid = 1'b1; tick(1); rtc_rd_valid = 1'b0;
        tick(3);
        acc = '0;
        for (int k = 1; k <= 10; k++) acc |= hab_log[k];
        check("pb_pulses", acc, 9'h020);
        check("pb_hab6", hab_log[6], 9'h020);
        wait_idle();
        bus_read(STAT, rd); check("pb_stat", rd, 8'h02);
        check("pb_f5", field_q[5*8 +: 8], 8'hC3);

        // DISCARD and COMMIT together: a pass with no pulses
        start_pass(8'h03);
        tick(10);
        acc = '0;
        for (int k = 1; k <= 10; k++) acc |= hab_log[k];
        check("dc_pulses", acc, 9'h000);
        check("dc_done10", done_log[10], 1'b1);
        wait_idle();
        bus_read(STAT, rd); check("dc_stat", rd, 8'h00);

        // Key events, clear-on-read, pulse during read
        key_pulse = 7'h05; tick(1); key_pulse = 7'h00;
        bus_read(KEYP, rd); check("key_first", rd, 8'h05);
        bus_read(KEYP, rd); check("key_cleared", rd, 8'h00);
        key_pulse = 7'h05; tick(1);
        key_pulse = 7'h02; bus_read(KEYP, rd); key_pulse = 7'h00;
        check("key_race_read", rd, 8'h05);
        bus_read(KEYP, rd); check("key_race_next", rd, 8'h02);

        // Reset in the middle of a five-field commit
        for (int i = 0; i < 4; i++) bus_write(8'(i), 8'h40 + 8'(i));
        bus_write(8'h05, 8'h45);
        start_pass(8'h01);
        tick(2);
        @(negedge clk);
        hab_log[3] = habilita;
        #1 reset = 1'b0;
        #1;
        check("mr_habilita", habilita, '0);
        check("mr_busy", commit_busy, 1'b0);
        check("mr_done", commit_done, 1'b0);
        check("mr_pulsed", hab_log[1] | hab_log[2] | hab_log[3], 9'h007);
        @(posedge clk); #1 reset = 1'b1;
        start_pass(8'h00);
        tick(12);
        dn = 1'b0;
        for (int k = 1; k <= 12; k++) dn |= done_log[k];
        check("mr_no_done", dn, 1'b0);
        check("mr_fields", field_q, '0);
        bus_read(STAT, rd); check("mr_stat", rd, 8'h00);

`ifdef PORT_BRIDGE_IRQ_EN
        key_pulse = 7'h10; tick(1); key_pulse = 7'h00;
        @(negedge clk); check("irq_pending_cycle", interrupt, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); check("irq_set", interrupt, 1'b1);
        interrupt_ack = 1'b1;
        @(posedge clk); #1 interrupt_ack = 1'b0;
        @(negedge clk); check("irq_acked", interrupt, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); check("irq_reassert", interrupt, 1'b1);
        @(posedge clk); #1;
        bus_read(KEYP, rd); check("irq_key", rd, 8'h10);
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
